// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, decode valid/ready
// channel, redirect input and invalid-PC exception outputs.
interface pc_fetch_unit_if #(
    parameter int IMEM_AW = 10
);
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               exc_invalid_pc;
    logic [31:0]        exc_badaddr;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
               exc_invalid_pc, exc_badaddr,
        input  imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
               exc_invalid_pc, exc_badaddr,
        output imem_ack, imem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// MIPS32 instruction-fetch initiator: range-checked PC, req/ack memory reads,
// valid/ready hand-off to decode and a sticky invalid-PC exception.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h00400000,
    parameter logic [31:0] TEXT_BASE  = 32'h00400000,
    parameter logic [31:0] TEXT_LIMIT = 32'h00400FFF,
    parameter int          IMEM_AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.master  fetch
);

    typedef enum logic [1:0] {BOOT, REQ, HOLD, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic        kill_q, kill_d;
    logic        exc_q, exc_d;
    logic        load_pc;

    function automatic logic legal(input logic [31:0] a);
        return (a >= TEXT_BASE) && (a <= TEXT_LIMIT) && (a[1:0] == 2'b00);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'd0;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            badaddr_q  <= 32'd0;
            kill_q     <= 1'b0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            badaddr_q  <= badaddr_d;
            kill_q     <= kill_d;
            exc_q      <= exc_d;
        end
    end

    // Any new PC value is range-checked on the way in; illegal ones land in FAULT.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        badaddr_d  = badaddr_q;
        kill_d     = kill_q;
        load_pc    = 1'b0;
        case (state_q)
            BOOT: state_d = legal(pc_q) ? REQ : FAULT;
            REQ: begin
                if (fetch.imem_ack) begin
                    if (kill_q || fetch.redirect_valid) begin
                        pc_d    = fetch.redirect_valid ? fetch.redirect_pc : pend_pc_q;
                        kill_d  = 1'b0;
                        load_pc = 1'b1;
                    end else begin
                        instr_d    = fetch.imem_rdata;
                        instr_pc_d = pc_q;
                        state_d    = HOLD;
                    end
                end else if (fetch.redirect_valid) begin
                    // The request stays on the bus; its data is dropped when it returns.
                    kill_d    = 1'b1;
                    pend_pc_d = fetch.redirect_pc;
                end
            end
            HOLD: begin
                if (fetch.redirect_valid) begin
                    pc_d    = fetch.redirect_pc;
                    load_pc = 1'b1;
                end else if (fetch.instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    load_pc = 1'b1;
                end
            end
            FAULT: begin
                if (fetch.redirect_valid) begin
                    pc_d    = fetch.redirect_pc;
                    load_pc = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
        if (load_pc) begin
            state_d = legal(pc_d) ? REQ : FAULT;
        end
        exc_d = (state_d == FAULT);
        if (state_d == FAULT) begin
            badaddr_d = pc_d;
        end
    end

    always_comb begin
        fetch.imem_req       = (state_q == REQ);
        fetch.imem_addr      = pc_q[IMEM_AW+1:2];
        fetch.instr_valid    = (state_q == HOLD);
        fetch.instr          = instr_q;
        fetch.instr_pc       = instr_pc_q;
        fetch.exc_invalid_pc = exc_q;
        fetch.exc_badaddr    = badaddr_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, streaming, kill-on-redirect, stall,
// text-segment overflow, illegal redirects and asynchronous reset.
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    bit   autoAck;
    int   assertCount;
    int   failCount;

    pc_fetch_unit_if #(.IMEM_AW(10)) bus ();

    pc_fetch_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fetch (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [9:0] a);
        return 32'hA5000000 | {22'd0, a};
    endfunction

    // Advance one clock and look #1 past the edge; a zero-wait memory answers here.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (autoAck) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = memWord(bus.imem_addr);
        end
    endtask

    task automatic doReset(input bit autoMode);
        autoAck            = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = 1'b0;
        rst_n              = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        autoAck = autoMode;
        cycle();
    endtask

    task automatic test_reset();
        #3;
        assertCount++;
        if (bus.imem_req !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req);
        end
        assertCount++;
        if (bus.instr_valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.instr_valid);
        end
        assertCount++;
        if (bus.instr !== 32'd0 || bus.instr_pc !== 32'd0) begin
            failCount++; $display("[TB] FAIL reset_instr: got %h/%h expected 0/0", bus.instr, bus.instr_pc);
        end
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b0 || bus.exc_badaddr !== 32'd0) begin
            failCount++; $display("[TB] FAIL reset_exc: got %b/%h expected 0/0", bus.exc_invalid_pc, bus.exc_badaddr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        assertCount++;
        if (bus.imem_req !== 1'b0) begin
            failCount++; $display("[TB] FAIL boot_req: got %b expected 0", bus.imem_req);
        end
        cycle();
        assertCount++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
            failCount++; $display("[TB] FAIL boot_first_req: got %b/%h expected 1/000", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        doReset(1'b1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            assertCount++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h00400000 + 32'(4 * i)) begin
                failCount++; $display("[TB] FAIL stream_pc[%0d]: got %b/%h expected 1/%h", i, bus.instr_valid, bus.instr_pc, 32'h00400000 + 32'(4 * i));
            end
            assertCount++;
            if (bus.instr !== memWord(10'(i))) begin
                failCount++; $display("[TB] FAIL stream_instr[%0d]: got %h expected %h", i, bus.instr, memWord(10'(i)));
            end
            cycle();
            assertCount++;
            if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'(i + 1)) begin
                failCount++; $display("[TB] FAIL stream_next[%0d]: got v=%b r=%b a=%h expected v=0 r=1 a=%h", i, bus.instr_valid, bus.imem_req, bus.imem_addr, 10'(i + 1));
            end
        end
        bus.instr_ready = 1'b0;
    endtask

    task automatic test_kill_redirect();
        doReset(1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h00400100;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            assertCount++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
                failCount++; $display("[TB] FAIL kill_wait[%0d]: got %b/%h expected 1/000", i, bus.imem_req, bus.imem_addr);
            end
            cycle();
        end
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'hDEADBEEF;
        assertCount++;
        if (bus.imem_addr !== 10'd0) begin
            failCount++; $display("[TB] FAIL kill_ack_addr: got %h expected 000", bus.imem_addr);
        end
        cycle();
        bus.imem_ack = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h040) begin
            failCount++; $display("[TB] FAIL kill_discard: got v=%b r=%b a=%h expected v=0 r=1 a=040", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h12345678;
        cycle();
        bus.imem_ack = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h00400100 || bus.instr !== 32'h12345678) begin
            failCount++; $display("[TB] FAIL kill_refetch: got %b/%h/%h expected 1/00400100/12345678", bus.instr_valid, bus.instr_pc, bus.instr);
        end
    endtask

    task automatic test_stall();
        doReset(1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            assertCount++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== memWord(10'd0) || bus.instr_pc !== 32'h00400000) begin
                failCount++; $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%h expected 1/%h/00400000", i, bus.instr_valid, bus.instr, bus.instr_pc, memWord(10'd0));
            end
            if (i == 4) bus.instr_ready = 1'b1;
            cycle();
        end
        bus.instr_ready = 1'b0;
        assertCount++;
        if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd1) begin
            failCount++; $display("[TB] FAIL stall_release: got v=%b r=%b a=%h expected v=0 r=1 a=001", bus.instr_valid, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_overflow();
        doReset(1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00400FFC;
        bus.imem_ack       = 1'b1;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.imem_rdata     = 32'h0BADF00D;
        assertCount++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h3FF) begin
            failCount++; $display("[TB] FAIL ovf_req: got %b/%h expected 1/3ff", bus.imem_req, bus.imem_addr);
        end
        cycle();
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        assertCount++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h00400FFC) begin
            failCount++; $display("[TB] FAIL ovf_last: got %b/%h expected 1/00400ffc", bus.instr_valid, bus.instr_pc);
        end
        cycle();
        bus.instr_ready = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b1 || bus.exc_badaddr !== 32'h00401000) begin
            failCount++; $display("[TB] FAIL ovf_exc: got %b/%h expected 1/00401000", bus.exc_invalid_pc, bus.exc_badaddr);
        end
        cycle();
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b1 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0) begin
            failCount++; $display("[TB] FAIL ovf_sticky: got e=%b r=%b v=%b expected e=1 r=0 v=0", bus.exc_invalid_pc, bus.imem_req, bus.instr_valid);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00400000;
        cycle();
        bus.redirect_valid = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'd0) begin
            failCount++; $display("[TB] FAIL ovf_recover: got e=%b r=%b a=%h expected e=0 r=1 a=000", bus.exc_invalid_pc, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_bad_redirect();
        doReset(1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00400002;
        bus.imem_ack       = 1'b1;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b1 || bus.exc_badaddr !== 32'h00400002 || bus.imem_req !== 1'b0) begin
            failCount++; $display("[TB] FAIL misaligned: got e=%b b=%h r=%b expected e=1 b=00400002 r=0", bus.exc_invalid_pc, bus.exc_badaddr, bus.imem_req);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h003FFFFC;
        cycle();
        bus.redirect_valid = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b1 || bus.exc_badaddr !== 32'h003FFFFC || bus.imem_req !== 1'b0) begin
            failCount++; $display("[TB] FAIL below_base: got e=%b b=%h r=%b expected e=1 b=003ffffc r=0", bus.exc_invalid_pc, bus.exc_badaddr, bus.imem_req);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00400010;
        cycle();
        bus.redirect_valid = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 10'h004) begin
            failCount++; $display("[TB] FAIL bad_recover: got e=%b r=%b a=%h expected e=0 r=1 a=004", bus.exc_invalid_pc, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_async_reset();
        doReset(1'b0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00500000;
        bus.imem_ack       = 1'b1;
        cycle();
        bus.redirect_valid = 1'b0;
        bus.imem_ack       = 1'b0;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b1) begin
            failCount++; $display("[TB] FAIL arst_pre_fault: got %b expected 1", bus.exc_invalid_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        assertCount++;
        if (bus.exc_invalid_pc !== 1'b0 || bus.exc_badaddr !== 32'd0) begin
            failCount++; $display("[TB] FAIL arst_fault: got %b/%h expected 0/0", bus.exc_invalid_pc, bus.exc_badaddr);
        end
        doReset(1'b0);
        assertCount++;
        if (bus.imem_req !== 1'b1) begin
            failCount++; $display("[TB] FAIL arst_pre_req: got %b expected 1", bus.imem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        assertCount++;
        if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.exc_invalid_pc !== 1'b0) begin
            failCount++; $display("[TB] FAIL arst_req: got r=%b v=%b e=%b expected 0/0/0", bus.imem_req, bus.instr_valid, bus.exc_invalid_pc);
        end
    endtask

    initial begin
        assertCount        = 0;
        failCount          = 0;
        autoAck            = 1'b0;
        rst_n              = 1'b0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'd0;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        test_reset();
        test_back_to_back();
        test_kill_redirect();
        test_stall();
        test_overflow();
        test_bad_redirect();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch initiator for the MIPS32 SOC.
- Holds the architectural PC and range-checks it against the text segment (0x00400000–0x00400FFF). Translates it to a 10-bit physical word index and issues req/ack reads to instruction memory.
- Hands fetched words to decode over a valid/ready interface.
- Raises a sticky invalid-PC exception on an out-of-range or misaligned PC until redirected to a legal address.

Parameters:
- RESET_PC, 32'h00400000, PC value loaded at reset.
- TEXT_BASE, 32'h00400000, lowest legal PC (inclusive).
- TEXT_LIMIT, 32'h00400FFF, highest legal byte address (inclusive).
- IMEM_AW, 10, physical word-index width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  IMEM_AW  physical word index, equal to pc[IMEM_AW+1:2].
- imem_ack  in  1  memory response strobe; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc valid toward decode.
- instr_ready  in  1  decode accepts the instruction.
- instr  out  32  fetched instruction.
- instr_pc  out  32  virtual PC of instr.
- redirect_valid  in  1  branch/jump/exception-vector request.
- redirect_pc  in  32  target virtual PC.
- exc_invalid_pc  out  1  sticky invalid-PC exception.
- exc_badaddr  out  32  offending virtual PC.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=BOOT, kill=0.
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0.
  - exc_invalid_pc=0, exc_badaddr=0.
- Legality function legal(a): a>=TEXT_BASE, a<=TEXT_LIMIT and a[1:0]==0. It is applied to every value loaded into pc on its way to REQ.
- Transitions:
  - BOOT: one cycle. Next cycle go to REQ if legal(pc), else FAULT.
  - REQ: imem_req=1 and imem_addr=pc[11:2], both held stable until imem_ack=1. Memory ack may come in the first REQ cycle.
- Ack in REQ with kill=0 and no redirect_valid:
  - Latch instr=imem_rdata and instr_pc=pc.
  - Next cycle instr_valid=1 and state=HOLD.
- redirect_valid in REQ without ack:
  - Set kill=1 and store redirect_pc in pend_pc. A later redirect overwrites pend_pc (latest wins).
  - imem_req and imem_addr stay unchanged; an outstanding request is never withdrawn.
- Ack in REQ with kill=1 or redirect_valid that cycle:
  - Discard the data.
  - Load pc with the target: redirect_pc if redirect_valid that cycle, else pend_pc.
  - Clear kill. Next cycle go to REQ if legal, else FAULT.
- HOLD: instr_valid=1 and instr/instr_pc held stable while instr_ready=0.
  - redirect_valid (priority over ready): drop the instruction; instr_valid=0 next cycle; pc=redirect_pc.
  - Else instr_ready=1: instr_valid=0 next cycle; pc=pc+4 (32-bit, no saturation).
  - The new pc goes to REQ if legal, else FAULT.
- Entering FAULT:
  - exc_invalid_pc=1 and exc_badaddr=pc in the same cycle FAULT is entered.
  - imem_req=0, instr_valid=0.
- In FAULT:
  - Only redirect_valid exits. It sets pc=redirect_pc and clears exc_invalid_pc next cycle.
  - The exit goes to REQ if legal, else FAULT is re-entered with exc_badaddr updated and exc_invalid_pc remaining 1.
- Throughput:
  - With zero-wait memory and instr_ready tied 1: REQ→HOLD→REQ, so one instruction per 2 cycles.
  - Latency is 1 cycle from ack to instr_valid.
- Sequential overflow: 0x00400FFC+4=0x00401000, which is illegal, so FAULT is entered with no memory request.
- Reset mid-transaction: asynchronous return to BOOT values. Memory must tolerate an abandoned request; no further ack is expected.

Test Plan:
- Reset release, zero-wait memory, instr_ready=1:
  - imem_req rises 1 cycle after BOOT with imem_addr=0.
  - instr_pc sequence is 0x00400000, 0x00400004, 0x00400008 with instr_valid every 2nd cycle.
- Memory ack delayed 3 cycles, and redirect_valid pulsed with redirect_pc=0x00400100 in the 2nd wait cycle:
  - imem_addr holds 0 until ack; the ack data is discarded with no instr_valid.
  - The next request has imem_addr=0x040.
- instr_ready held 0 for 5 cycles in HOLD: instr and instr_pc stay stable with instr_valid=1. Releasing ready gives the next imem_addr = previous+1.
- Fetch at 0x00400FFC, then ready:
  - exc_invalid_pc=1 with exc_badaddr=0x00401000; imem_req stays 0.
  - redirect_pc=0x00400000 clears the exception and fetches imem_addr=0.
- Redirect to 0x00400002 (misaligned) and to 0x003FFFFC: each enters FAULT with the matching exc_badaddr and no memory request.
- Assert rst_n=0 mid-REQ while imem_req=1: imem_req, instr_valid and exc_invalid_pc drop to 0 without a clock edge.
